action_ctrl_v2: RTL and testbench
=================================

# action_ctrl_v2

Parametrised player-action controller for the I-wanna game core. It sits between the raw keyboard/button decoder and the physics/position updater. It debounces the key inputs and latches facing direction. It runs a walk/jump/fall state machine with variable-height jump and multi-jump, and emits per-frame move pulses on a game-tick strobe.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles before a key's debounced level changes (≥2).
- `TICK_DIV`, default 4: clock cycles per game tick (≥2).
- `MAX_JUMPS`, default 2: jumps allowed before landing (1 = single jump, 2 = double jump; ≤7).
- `JUMP_HOLD_MAX`, default 6: maximum ticks an ascent continues while jump is held (≥1).
- `clk` input 1: single system clock.
- `rst` input 1: synchronous, active-high reset.
- `keys` input 4: raw keys. [0] jump, [1] left, [2] right, [3] shoot.
- `on_ground` input 1: from physics, player is standing on a surface.
- `direction` output 1: facing. 0 = right, 1 = left.
- `action` output 2: 00 IDLE, 01 WALK, 10 JUMP (ascending), 11 FALL.
- `move_signal` output 4: one-cycle pulses, coincident with a tick. [0] ascend, [1] step left, [2] step right, [3] shoot.
- `jumps_used` output 3: jumps consumed since last landing.

## Operation
- Debounce: each key has its own counter. The debounced level follows the raw level once the raw level has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the counter.
- Edges: rising edges of debounced jump and shoot set sticky pending flags. The flags are consumed at the next tick and cleared after use. Holding a key never re-triggers.
- Horizontal: left-only gives step left and direction=1. Right-only gives step right and direction=0. Both or neither: no step, direction unchanged.
- FSM, evaluated only on tick:
  - IDLE/WALK: a jump pending with jumps_used<MAX_JUMPS goes to JUMP. It sets jumps_used+1 and hold_cnt=0. Otherwise, !on_ground goes to FALL with jumps_used=max(jumps_used,1), so walking off a ledge costs one jump. Otherwise, a step active gives WALK, else IDLE.
  - JUMP: emit ascend pulse and hold_cnt+1. Jump released or hold_cnt reaches JUMP_HOLD_MAX goes to FALL. A new jump pending with jumps_used<MAX_JUMPS restarts JUMP: jumps_used+1, hold_cnt=0.
  - FALL: on_ground goes to WALK/IDLE (by step) with jumps_used=0. A jump pending with jumps_used<MAX_JUMPS goes to JUMP. Landing has priority over jump on the same tick; the pending flag survives to the next tick.
- Jump pending with jumps_used==MAX_JUMPS: flag is discarded at the tick.
- Steps and shoot are produced in every state.
- jumps_used saturates at MAX_JUMPS. hold_cnt saturates at JUMP_HOLD_MAX.

## Timing
- Reset: direction=0, action=00, move_signal=0, jumps_used=0. Debounced levels=0, counters=0, pending flags=0, tick counter=0.
- Tick strobe is high on the cycle the tick counter equals TICK_DIV-1. The first tick is TICK_DIV cycles after reset release.
- A raw key change stable from cycle t shows in the debounced level at cycle t+DEBOUNCE_CYCLES.
- action, direction and jumps_used are registered and update the cycle after the tick. move_signal is registered and high for exactly that one cycle.
- Reset mid-jump returns everything to reset values on the next edge. Raw keys held through reset are treated as debounced-0 and must re-debounce.

## Structure
- Package `action_pkg`: action encodings (IDLE/WALK/JUMP/FALL), key index constants (KEY_JUMP=0, KEY_LEFT=1, KEY_RIGHT=2, KEY_SHOOT=3), move_signal bit indices.
- Sub-module `key_debounce`, parametrised by DEBOUNCE_CYCLES and instantiated once per key. It outputs the debounced level and a rising-edge pulse.
- Tick divider, FSM and counters live in the top module.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, TICK_DIV=8, MAX_JUMPS=2, JUMP_HOLD_MAX=3.
- Bounce: keys[2] toggles 1/0 every 2 cycles for 20 cycles, then holds 1 with on_ground=1 → no step during bouncing. Debounced after 4 stable cycles; move_signal[2] pulses every 8 cycles; action=01; direction=0.
- Variable jump: on_ground=1, jump held for 40 cycles → action=10 with exactly 3 ascend pulses, then action=11. Drop on_ground to 0 and release jump. Raise on_ground → action=00, jumps_used=0.
- Double jump: jump pressed, released, pressed again while in FALL → second JUMP with jumps_used=2. A third press before landing → no ascend pulse, action stays 11.
- Ledge walk-off: on_ground→0 during WALK → action=11, jumps_used=1. One air jump is allowed, then jumps_used=2.
- Conflict/shoot: left+right held → no step pulses, direction unchanged. A shoot press → exactly one move_signal[3] pulse even if held 100 cycles.
- Reset mid-jump: assert rst during JUMP → all outputs equal reset values the next cycle. With jump held across reset → no jump until 4 cycles after release of rst plus the next tick.

Source files
------------

// File: rtl/action_pkg.sv
// Shared encodings for the player-action controller: action states, key and move bit positions.
package action_pkg;

    typedef enum logic [1:0] {
        ACT_IDLE = 2'b00,
        ACT_WALK = 2'b01,
        ACT_JUMP = 2'b10,
        ACT_FALL = 2'b11
    } action_e;

    localparam int NUM_KEYS  = 4;

    localparam int KEY_JUMP  = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_RIGHT = 2;
    localparam int KEY_SHOOT = 3;

    localparam int MV_ASCEND = 0;
    localparam int MV_LEFT   = 1;
    localparam int MV_RIGHT  = 2;
    localparam int MV_SHOOT  = 3;

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer: level follows raw after DEBOUNCE_CYCLES consecutive differing samples.
// rise_o is combinational and high in the cycle whose closing edge raises the level.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        // Any sample equal to the current level restarts the count.
        if (raw_i != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = raw_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_d & ~level_q;

endmodule

// File: rtl/action_ctrl_v2.sv
// Player-action controller: debounced keys drive a tick-evaluated idle/walk/jump/fall FSM
// with variable-height and multi-jump; all outputs register on the cycle after each tick.
module action_ctrl_v2
    import action_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 4,
    parameter int MAX_JUMPS       = 2,
    parameter int JUMP_HOLD_MAX   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keys,
    input  logic       on_ground,
    output logic       direction,
    output logic [1:0] action,
    output logic [3:0] move_signal,
    output logic [2:0] jumps_used
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(JUMP_HOLD_MAX + 1);

    logic [NUM_KEYS-1:0] lvl, rise;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i  (clk),
            .rst_i  (rst),
            .raw_i  (keys[k]),
            .level_o(lvl[k]),
            .rise_o (rise[k])
        );
    end

    logic unused_key_bits;
    assign unused_key_bits = ^{lvl[KEY_SHOOT], rise[KEY_LEFT], rise[KEY_RIGHT]};

    logic [TW-1:0] tick_q, tick_d;
    logic          tick;

    assign tick   = (tick_q == TW'(TICK_DIV - 1));
    assign tick_d = tick ? '0 : tick_q + 1'b1;

    action_e       state_q, state_d;
    logic [2:0]    jumps_q, jumps_d;
    logic [HW-1:0] hold_q, hold_d, hold_inc;
    logic          dir_q, dir_d;
    logic [3:0]    move_q, move_d;
    logic          jpend_q, jpend_d;
    logic          spend_q, spend_d;

    logic step_l, step_r, can_jump;

    always_comb begin
        step_l   = lvl[KEY_LEFT] & ~lvl[KEY_RIGHT];
        step_r   = lvl[KEY_RIGHT] & ~lvl[KEY_LEFT];
        can_jump = jpend_q && (jumps_q < 3'(MAX_JUMPS));
        hold_inc = (hold_q == HW'(JUMP_HOLD_MAX)) ? hold_q : hold_q + 1'b1;

        state_d = state_q;
        jumps_d = jumps_q;
        hold_d  = hold_q;
        dir_d   = dir_q;
        move_d  = '0;
        jpend_d = jpend_q;
        spend_d = spend_q;

        if (tick) begin
            move_d[MV_LEFT]  = step_l;
            move_d[MV_RIGHT] = step_r;
            move_d[MV_SHOOT] = spend_q;
            spend_d          = 1'b0;
            if (step_l) begin
                dir_d = 1'b1;
            end else if (step_r) begin
                dir_d = 1'b0;
            end
            // A press with no jumps left is thrown away rather than banked.
            if (jpend_q && !can_jump) begin
                jpend_d = 1'b0;
            end

            unique case (state_q)
                ACT_IDLE, ACT_WALK: begin
                    if (can_jump) begin
                        state_d = ACT_JUMP;
                        jumps_d = jumps_q + 3'd1;
                        hold_d  = '0;
                        jpend_d = 1'b0;
                    end else if (!on_ground) begin
                        state_d = ACT_FALL;
                        jumps_d = (jumps_q == 3'd0) ? 3'd1 : jumps_q;
                    end else begin
                        state_d = (step_l || step_r) ? ACT_WALK : ACT_IDLE;
                    end
                end
                ACT_JUMP: begin
                    move_d[MV_ASCEND] = 1'b1;
                    hold_d            = hold_inc;
                    if (can_jump) begin
                        jumps_d = jumps_q + 3'd1;
                        hold_d  = '0;
                        jpend_d = 1'b0;
                    end else if (!lvl[KEY_JUMP] || hold_inc == HW'(JUMP_HOLD_MAX)) begin
                        state_d = ACT_FALL;
                    end
                end
                ACT_FALL: begin
                    // Landing wins; a usable pending jump is kept for the next tick.
                    if (on_ground) begin
                        state_d = (step_l || step_r) ? ACT_WALK : ACT_IDLE;
                        jumps_d = 3'd0;
                    end else if (can_jump) begin
                        state_d = ACT_JUMP;
                        jumps_d = jumps_q + 3'd1;
                        hold_d  = '0;
                        jpend_d = 1'b0;
                    end
                end
            endcase
        end

        if (rise[KEY_JUMP]) begin
            jpend_d = 1'b1;
        end
        if (rise[KEY_SHOOT]) begin
            spend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q  <= '0;
            state_q <= ACT_IDLE;
            jumps_q <= 3'd0;
            hold_q  <= '0;
            dir_q   <= 1'b0;
            move_q  <= '0;
            jpend_q <= 1'b0;
            spend_q <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            state_q <= state_d;
            jumps_q <= jumps_d;
            hold_q  <= hold_d;
            dir_q   <= dir_d;
            move_q  <= move_d;
            jpend_q <= jpend_d;
            spend_q <= spend_d;
        end
    end

    assign direction   = dir_q;
    assign action      = state_q;
    assign move_signal = move_q;
    assign jumps_used  = jumps_q;

endmodule

// File: tb/tb_action_ctrl_v2.sv
// Directed bench for action_ctrl_v2 with DEBOUNCE_CYCLES=4, TICK_DIV=8, MAX_JUMPS=2, JUMP_HOLD_MAX=3.
module tb_action_ctrl_v2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] keys = 4'b0000;
    logic       on_ground = 1'b1;
    logic       direction;
    logic [1:0] action;
    logic [3:0] move_signal;
    logic [2:0] jumps_used;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    action_ctrl_v2 #(
        .DEBOUNCE_CYCLES(4),
        .TICK_DIV       (8),
        .MAX_JUMPS      (2),
        .JUMP_HOLD_MAX  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .keys       (keys),
        .on_ground  (on_ground),
        .direction  (direction),
        .action     (action),
        .move_signal(move_signal),
        .jumps_used (jumps_used)
    );

    // Reset is released right after a falling edge; ticks then register on rising edges 8, 16, ...
    task automatic do_reset(input logic [3:0] k, input logic og);
        @(negedge clk);
        rst = 1'b1;
        keys = k;
        on_ground = og;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_action(input logic [1:0] a, input int budget, output int n);
        n = 0;
        while (action !== a && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        do_reset(4'b0000, 1'b1);
        checks++; if (direction !== 1'b0) begin failures++; $display("FAIL reset_direction got=%b exp=0", direction); end
        checks++; if (action !== 2'b00) begin failures++; $display("FAIL reset_action got=%b exp=00", action); end
        checks++; if (move_signal !== 4'b0000) begin failures++; $display("FAIL reset_move got=%b exp=0000", move_signal); end
        checks++; if (jumps_used !== 3'd0) begin failures++; $display("FAIL reset_jumps got=%0d exp=0", jumps_used); end
    endtask

    task automatic test_bounce;
        int cnt;
        int n;
        do_reset(4'b0000, 1'b1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            keys[2] = ((i / 2) % 2 == 0);
            @(negedge clk);
            if (move_signal[2]) cnt++;
        end
        checks++; if (cnt !== 0) begin failures++; $display("FAIL bounce_no_step got=%0d exp=0", cnt); end
        keys[2] = 1'b1;
        n = 0;
        while (move_signal[2] !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 12) begin failures++; $display("FAIL bounce_first_step_latency got=%0d exp=12", n); end
        checks++; if (action !== 2'b01) begin failures++; $display("FAIL bounce_walk got=%b exp=01", action); end
        checks++; if (direction !== 1'b0) begin failures++; $display("FAIL bounce_dir_right got=%b exp=0", direction); end
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (move_signal[2]) cnt++;
        end
        checks++; if (cnt !== 4) begin failures++; $display("FAIL bounce_step_rate got=%0d exp=4", cnt); end
        keys = 4'b0010;
        n = 0;
        while (move_signal[1] !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++; if (move_signal !== 4'b0010) begin failures++; $display("FAIL left_step got=%b exp=0010", move_signal); end
        checks++; if (direction !== 1'b1) begin failures++; $display("FAIL left_dir got=%b exp=1", direction); end
    endtask

    task automatic test_var_jump;
        int n;
        int asc;
        bit saw_jump;
        do_reset(4'b0000, 1'b1);
        repeat (4) @(negedge clk);
        keys[0] = 1'b1;
        n = 0;
        asc = 0;
        saw_jump = 1'b0;
        while (action !== 2'b11 && n < 80) begin
            @(negedge clk);
            n++;
            if (move_signal[0]) asc++;
            if (action === 2'b10) saw_jump = 1'b1;
        end
        on_ground = 1'b0;
        keys[0] = 1'b0;
        checks++; if (action !== 2'b11) begin failures++; $display("FAIL varjump_fall got=%b exp=11", action); end
        checks++; if (saw_jump !== 1'b1) begin failures++; $display("FAIL varjump_saw_jump got=%b exp=1", saw_jump); end
        checks++; if (asc !== 3) begin failures++; $display("FAIL varjump_ascends got=%0d exp=3", asc); end
        checks++; if (jumps_used !== 3'd1) begin failures++; $display("FAIL varjump_jumps got=%0d exp=1", jumps_used); end
        repeat (20) @(negedge clk);
        checks++; if (action !== 2'b11) begin failures++; $display("FAIL varjump_airborne got=%b exp=11", action); end
        on_ground = 1'b1;
        wait_action(2'b00, 20, n);
        checks++; if (action !== 2'b00) begin failures++; $display("FAIL varjump_land got=%b exp=00", action); end
        checks++; if (jumps_used !== 3'd0) begin failures++; $display("FAIL varjump_land_jumps got=%0d exp=0", jumps_used); end
    endtask

    task automatic test_double_jump;
        int n;
        int asc;
        int bad;
        do_reset(4'b0000, 1'b1);
        repeat (4) @(negedge clk);
        keys[0] = 1'b1;
        wait_action(2'b10, 30, n);
        checks++; if (action !== 2'b10) begin failures++; $display("FAIL dbl_first_jump got=%b exp=10", action); end
        on_ground = 1'b0;
        keys[0] = 1'b0;
        wait_action(2'b11, 40, n);
        checks++; if (action !== 2'b11) begin failures++; $display("FAIL dbl_first_fall got=%b exp=11", action); end
        keys[0] = 1'b1;
        wait_action(2'b10, 30, n);
        checks++; if (action !== 2'b10) begin failures++; $display("FAIL dbl_second_jump got=%b exp=10", action); end
        checks++; if (jumps_used !== 3'd2) begin failures++; $display("FAIL dbl_second_jumps got=%0d exp=2", jumps_used); end
        keys[0] = 1'b0;
        wait_action(2'b11, 40, n);
        checks++; if (action !== 2'b11) begin failures++; $display("FAIL dbl_second_fall got=%b exp=11", action); end
        keys[0] = 1'b1;
        asc = 0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (move_signal[0]) asc++;
            if (action !== 2'b11) bad++;
        end
        checks++; if (asc !== 0) begin failures++; $display("FAIL dbl_third_ascend got=%0d exp=0", asc); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL dbl_third_state_cycles got=%0d exp=0", bad); end
        checks++; if (jumps_used !== 3'd2) begin failures++; $display("FAIL dbl_third_jumps got=%0d exp=2", jumps_used); end
        keys[0] = 1'b0;
        on_ground = 1'b1;
        wait_action(2'b00, 30, n);
        checks++; if (jumps_used !== 3'd0) begin failures++; $display("FAIL dbl_land_jumps got=%0d exp=0", jumps_used); end
    endtask

    task automatic test_ledge;
        int n;
        do_reset(4'b0100, 1'b1);
        wait_action(2'b01, 30, n);
        checks++; if (action !== 2'b01) begin failures++; $display("FAIL ledge_walk got=%b exp=01", action); end
        on_ground = 1'b0;
        wait_action(2'b11, 20, n);
        checks++; if (action !== 2'b11) begin failures++; $display("FAIL ledge_fall got=%b exp=11", action); end
        checks++; if (jumps_used !== 3'd1) begin failures++; $display("FAIL ledge_jumps got=%0d exp=1", jumps_used); end
        keys[0] = 1'b1;
        wait_action(2'b10, 30, n);
        checks++; if (action !== 2'b10) begin failures++; $display("FAIL ledge_air_jump got=%b exp=10", action); end
        checks++; if (jumps_used !== 3'd2) begin failures++; $display("FAIL ledge_air_jumps got=%0d exp=2", jumps_used); end
        keys = 4'b0000;
    endtask

    task automatic test_conflict_shoot;
        int n;
        int cnt;
        do_reset(4'b0010, 1'b1);
        n = 0;
        while (move_signal[1] !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++; if (direction !== 1'b1) begin failures++; $display("FAIL conflict_pre_dir got=%b exp=1", direction); end
        keys = 4'b0110;
        repeat (8) @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (move_signal[1] || move_signal[2]) cnt++;
        end
        checks++; if (cnt !== 0) begin failures++; $display("FAIL conflict_steps got=%0d exp=0", cnt); end
        checks++; if (direction !== 1'b1) begin failures++; $display("FAIL conflict_dir got=%b exp=1", direction); end
        checks++; if (action !== 2'b00) begin failures++; $display("FAIL conflict_idle got=%b exp=00", action); end
        keys = 4'b1110;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (move_signal[3]) cnt++;
        end
        checks++; if (cnt !== 1) begin failures++; $display("FAIL shoot_pulses got=%0d exp=1", cnt); end
        keys = 4'b0000;
    endtask

    task automatic test_reset_mid_jump;
        int n;
        do_reset(4'b0000, 1'b1);
        repeat (4) @(negedge clk);
        keys[0] = 1'b1;
        wait_action(2'b10, 30, n);
        checks++; if (action !== 2'b10) begin failures++; $display("FAIL rmj_in_jump got=%b exp=10", action); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (action !== 2'b00) begin failures++; $display("FAIL rmj_action got=%b exp=00", action); end
        checks++; if (jumps_used !== 3'd0) begin failures++; $display("FAIL rmj_jumps got=%0d exp=0", jumps_used); end
        checks++; if (move_signal !== 4'b0000) begin failures++; $display("FAIL rmj_move got=%b exp=0000", move_signal); end
        checks++; if (direction !== 1'b0) begin failures++; $display("FAIL rmj_direction got=%b exp=0", direction); end
        rst = 1'b0;
        n = 0;
        while (action !== 2'b10 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 8) begin failures++; $display("FAIL rmj_rejump_latency got=%0d exp=8", n); end
        checks++; if (jumps_used !== 3'd1) begin failures++; $display("FAIL rmj_rejump_jumps got=%0d exp=1", jumps_used); end
        keys = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_var_jump();
        test_double_jump();
        test_ledge();
        test_conflict_shoot();
        test_reset_mid_jump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
